// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode constants and the
// wrapping pointer increment used by single- and dual-clock variants.
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // Explicit wrap so non-power-of-two depths never rely on binary overflow.
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port and one
// asynchronous read port.
module fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers and level,
    // so clearing it would only add a reset net to every storage bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : fifo_ram

// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read, occupancy, threshold flags, synchronous flush and sticky error flags.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int FWFT      = MODE_STD,
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW + 1)'(AF_THRESH);
    localparam logic [AW:0] LVL_AE   = (AW + 1)'(AE_THRESH);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] ram_rdata;
    logic              rd_acc, wr_acc;

    assign empty        = (level_q == '0);
    assign full         = (level_q == LVL_FULL);
    assign almost_empty = (level_q <= LVL_AE);
    assign almost_full  = (level_q >= LVL_AF);
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

    // A full FIFO still accepts a write when the same edge pops a word.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    fifo_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc && !flush),
        .waddr(wr_ptr_q),
        .wdata(din),
        .raddr(rd_ptr_q),
        .rdata(ram_rdata)
    );

    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            dout_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = AW'(ptr_inc(int'(wr_ptr_q), DEPTH));
            end
            if (rd_acc) begin
                rd_ptr_d = AW'(ptr_inc(int'(rd_ptr_q), DEPTH));
                dout_d   = ram_rdata;
            end
            if (wr_acc && !rd_acc) begin
                level_d = level_q + 1'b1;
            end else if (rd_acc && !wr_acc) begin
                level_d = level_q - 1'b1;
            end
            if (wr_en && !wr_acc) begin
                ovf_d = 1'b1;
            end
            if (rd_en && !rd_acc) begin
                unf_d = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // In FWFT mode the head word is shown combinationally from the array.
    assign dout = (FWFT == MODE_FWFT) ? ram_rdata : dout_q;

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: a vector table for a DEPTH=4 standard FIFO,
// plus sequences for a DEPTH=5 wrap, FWFT mode and asynchronous reset.
module tb_param_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // DUT A: 8-bit, DEPTH 4, standard read
    logic       fl_a, wr_a, rd_a;
    logic [7:0] din_a, dout_a;
    logic       e_a, f_a, ae_a, af_a, ov_a, un_a;
    logic [2:0] lvl_a;

    param_fifo #(.DATA_W(8), .DEPTH(4), .FWFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(fl_a), .wr_en(wr_a), .din(din_a), .rd_en(rd_a),
        .dout(dout_a), .empty(e_a), .full(f_a), .almost_empty(ae_a), .almost_full(af_a),
        .level(lvl_a), .overflow(ov_a), .underflow(un_a)
    );

    // DUT B: 8-bit, DEPTH 5, standard read
    logic       fl_b, wr_b, rd_b;
    logic [7:0] din_b, dout_b;
    logic       e_b, f_b, ae_b, af_b, ov_b, un_b;
    logic [3:0] lvl_b;

    param_fifo #(.DATA_W(8), .DEPTH(5), .FWFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(fl_b), .wr_en(wr_b), .din(din_b), .rd_en(rd_b),
        .dout(dout_b), .empty(e_b), .full(f_b), .almost_empty(ae_b), .almost_full(af_b),
        .level(lvl_b), .overflow(ov_b), .underflow(un_b)
    );

    // DUT C: 16-bit, DEPTH 4, FWFT
    logic        fl_c, wr_c, rd_c;
    logic [15:0] din_c, dout_c;
    logic        e_c, f_c, ae_c, af_c, ov_c, un_c;
    logic [2:0]  lvl_c;

    param_fifo #(.DATA_W(16), .DEPTH(4), .FWFT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(fl_c), .wr_en(wr_c), .din(din_c), .rd_en(rd_c),
        .dout(dout_c), .empty(e_c), .full(f_c), .almost_empty(ae_c), .almost_full(af_c),
        .level(lvl_c), .overflow(ov_c), .underflow(un_c)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic       fl;
        logic [7:0] din;
        logic [2:0] lvl;
        logic       ov;
        logic       un;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wr, input logic rd, input logic fl, input logic [7:0] din,
                       input logic [2:0] lvl, input logic ov, input logic un, input logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.rd = rd; v.fl = fl; v.din = din;
        v.lvl = lvl; v.ov = ov; v.un = un; v.dout = dout;
        vecs.push_back(v);
    endtask

    // Expected {empty, full, almost_empty, almost_full} for DEPTH 4, AF 3, AE 1.
    function automatic logic [3:0] flags_a(input logic [2:0] lvl);
        return {lvl == 3'd0, lvl == 3'd4, lvl <= 3'd1, lvl >= 3'd3};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {fl_a, wr_a, rd_a, din_a} = '0;
        {fl_b, wr_b, rd_b, din_b} = '0;
        {fl_c, wr_c, rd_c, din_c} = '0;
        #2;
        check("reset_a", {lvl_a, e_a, f_a, ae_a, af_a, ov_a, un_a, dout_a},
              {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        #10 rst_n = 1'b1;

        //   wr    rd    fl    din    lvl ov    un    dout
        add(1'b1, 1'b0, 1'b0, 8'hA1, 3'd1, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'hA2, 3'd2, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'hA3, 3'd3, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'hA4, 3'd4, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'hEE, 3'd4, 1'b1, 1'b0, 8'h00); // write while full
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b1, 1'b0, 8'hA1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b1, 1'b0, 8'hA2);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 1'b0, 8'hA3);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'hA4);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1, 8'hA4); // read while empty
        add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h33, 3'd1, 1'b0, 1'b1, 8'h00); // rd+wr on empty
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h33);
        add(1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'h22, 3'd2, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b0, 1'b0, 8'h44, 3'd4, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b0, 8'h55, 3'd4, 1'b0, 1'b0, 8'h11); // rd+wr on full
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h22);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 8'h33);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h44);
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h55);
        add(1'b1, 1'b0, 1'b0, 8'h77, 3'd1, 1'b0, 1'b0, 8'h55);
        add(1'b1, 1'b0, 1'b1, 8'h88, 3'd0, 1'b0, 1'b0, 8'h00); // flush beats write
        add(1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h00); // nothing was stored

        for (int i = 0; i < vecs.size(); i++) begin
            wr_a = vecs[i].wr; rd_a = vecs[i].rd; fl_a = vecs[i].fl; din_a = vecs[i].din;
            tick();
            check($sformatf("vec_a[%0d]", i),
                  {lvl_a, e_a, f_a, ae_a, af_a, ov_a, un_a, dout_a},
                  {vecs[i].lvl, flags_a(vecs[i].lvl), vecs[i].ov, vecs[i].un, vecs[i].dout});
            {wr_a, rd_a, fl_a} = '0;
        end

        // DEPTH 5: 12 words streamed through a 3-deep backlog, wrapping twice.
        for (int i = 0; i < 3; i++) begin
            wr_b = 1'b1; din_b = 8'(i);
            tick();
            check($sformatf("wrap_fill[%0d]", i), {4'h0, lvl_b}, {4'h0, 4'(i + 1)});
        end
        for (int i = 3; i < 12; i++) begin
            wr_b = 1'b1; rd_b = 1'b1; din_b = 8'(i);
            tick();
            check($sformatf("wrap_pair[%0d]", i), {lvl_b, dout_b}, {4'd3, 8'(i - 3)});
        end
        wr_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_b = 1'b1;
            tick();
            check($sformatf("wrap_drain[%0d]", i), {lvl_b, dout_b}, {4'(2 - i), 8'(9 + i)});
        end
        rd_b = 1'b0;
        check("wrap_flags", {e_b, f_b, ov_b, un_b}, 4'b1000);

        // FWFT sequences
        wr_c = 1'b1; din_c = 16'hBEEF;
        tick();
        check("fwft_first", {e_c, dout_c}, {1'b0, 16'hBEEF});
        wr_c = 1'b0; rd_c = 1'b1;
        tick();
        check("fwft_pop", {e_c, lvl_c}, {1'b1, 3'd0});
        wr_c = 1'b1; rd_c = 1'b0; din_c = 16'h0001;
        tick();
        check("fwft_b2b_0", {lvl_c, dout_c}, {3'd1, 16'h0001});
        wr_c = 1'b1; rd_c = 1'b1; din_c = 16'h0002;
        tick();
        check("fwft_b2b_1", {lvl_c, dout_c}, {3'd1, 16'h0002});
        wr_c = 1'b0; rd_c = 1'b1;
        tick();
        check("fwft_b2b_end", {e_c, ov_c, un_c}, 3'b100);
        rd_c = 1'b0;

        // Async reset with three words held and a non-zero dout.
        for (int i = 1; i <= 4; i++) begin
            wr_a = 1'b1; din_a = 8'(i);
            tick();
        end
        wr_a = 1'b0; rd_a = 1'b1;
        tick();
        rd_a = 1'b0;
        check("pre_reset", {lvl_a, dout_a}, {3'd3, 8'h01});
        #3 rst_n = 1'b0;
        #1;
        check("async_reset", {lvl_a, e_a, f_a, ae_a, af_a, ov_a, un_a, dout_a},
              {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        #10 rst_n = 1'b1;
        tick();
        check("post_reset", {lvl_a, e_a}, {3'd0, 1'b1});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_param_fifo

// File: doc/param_fifo.md
# param_fifo

Parametrised single-clock FIFO: the successor to the fixed 8-bit, power-of-two buffer used in the SPI read/collection path. It adds configurable data width and arbitrary depth, a first-word-fall-through (FWFT) read mode, an occupancy output, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags. It sits between the SPI shift logic and its consumer, decoupling byte arrival from downstream reads.

## Interface
- DATA_W, 8, data word width (≥1)
- DEPTH, 4, number of entries (≥2, any integer, not necessarily a power of two)
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AF_THRESH, DEPTH-1, almost_full asserts when level ≥ AF_THRESH (1..DEPTH)
- AE_THRESH, 1, almost_empty asserts when level ≤ AE_THRESH (0..DEPTH-1)
- AW (local), $clog2(DEPTH), pointer width
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of contents, pointers, level and error flags
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read (pop) request
- dout  out  DATA_W  read data
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- almost_empty  out  1  level ≤ AE_THRESH
- almost_full  out  1  level ≥ AF_THRESH
- level  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not simultaneously popped
- underflow  out  1  sticky: read attempted while empty

## Operation
- Accepted write: wr_en && (!full || rd_acc). Accepted read: rd_en && !empty.
- Pointers wrap explicitly from DEPTH-1 to 0; no reliance on natural binary wrap.
- Level: +1 on write only, -1 on read only, unchanged on both or neither.
- Full with rd_en && wr_en: both accepted, level stays DEPTH, oldest word popped, new word stored.
- Empty with rd_en && wr_en: write accepted, read rejected, underflow set, level becomes 1.
- Rejected write when full sets overflow; memory and pointers are unchanged. Rejected read when empty sets underflow.
- overflow/underflow stay set until flush or reset.
- Standard mode: on an accepted read, dout loads mem[rd_ptr] at the edge; otherwise dout holds.
- FWFT mode: dout = mem[rd_ptr] whenever !empty, and rd_en acknowledges the displayed word. dout is don't-care while empty; the bench must not check it then.
- Flush has priority over rd_en and wr_en in the same cycle. It zeroes pointers, level, overflow, underflow, and standard-mode dout. Memory contents are not cleared.
- Flags are decoded from the registered level and change only at clock edges.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, level 0, dout 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0.
- Reset deassertion: the first active edge is the one after rst_n rises.
- Write to visible: a word written at edge N makes empty 0 and level 1 after edge N. In FWFT mode dout shows that word after edge N.
- Standard read latency: 1 cycle. rd_en sampled at edge N gives data on dout after edge N.
- FWFT read: the pop at edge N presents the next word, or empty, after edge N.
- Flags and level reflect all accepted operations of edge N immediately after edge N.
- Reset mid-operation: all state is lost, with no partial write/read completion requirement.

## Structure
- Shared package fifo_pkg: MODE_STD = 0 and MODE_FWFT = 1 constants, plus a ptr_inc helper (wrap at DEPTH-1) reused by future async/dual-clock variants.
- Sub-module fifo_ram: DEPTH×DATA_W register array, one synchronous write port and one asynchronous read port. The top level owns the pointers, level, flags and the dout register.
- Estimated size: about 200 lines for the top level plus about 40 for fifo_ram.

## Test plan
- Reset/fill/drain (DATA_W=8, DEPTH=4, standard): write 0xA1..0xA4.
  - Expect full=1, level=4, almost_full=1 (at level 3 and 4).
  - Read 4 → dout 0xA1..0xA4, each 1 cycle after rd_en. Then empty=1.
- Non-power-of-two wrap (DEPTH=5): run 12 write/read pairs of 0x00..0x0B across the wrap boundary.
  - Expect in-order data and level never >5.
  - Expect no overflow/underflow.
- Simultaneous ops:
  - On full (DEPTH=4), rd+wr of 0x55 → level stays 4, oldest word out, 0x55 read last.
  - On empty, rd+wr of 0x33 → level 1, underflow=1, and 0x33 is next read.
- Errors and flush:
  - Write while full → overflow=1 and contents intact.
  - Read while empty → underflow=1.
  - Flush asserted with wr_en → level 0, empty 1, both flags 0, and the write is discarded.
- FWFT (DATA_W=16, FWFT=1): write 0xBEEF to empty.
  - Expect dout=0xBEEF the cycle after.
  - Pop → empty=1. Back-to-back writes 0x0001, 0x0002 with a pop each cycle → dout sequence 0x0001, 0x0002.
- Async reset mid-stream: assert rst_n low between edges with level=3 → all outputs at reset values immediately, without waiting for a clock edge.
